// File: rtl/lr_sc_reservation_unit.sv
// MEM-stage LR.W/SC.W reservation tracker: holds one granule reservation and gates SC writes.
// Optional reservation expiry is enabled by defining RESERVATION_TIMEOUT_EN.
module lr_sc_reservation_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int GRANULE_BITS   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic                  stall,
    input  logic                  isLr,
    input  logic                  isSc,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  snoopValid,
    input  logic [ADDR_WIDTH-1:0] snoopAddress,
    output logic                  scWriteEnable,
    output logic [31:0]           scResult,
    output logic                  reservationValid,
    output logic [ADDR_WIDTH-1:0] reservedAddress
);

    typedef enum logic {IDLE, RESERVED} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  commit;
    logic                  lr_commit;
    logic                  sc_commit;
    logic                  st_commit;
    logic                  sc_success;
    logic                  expired;

    function automatic logic granule_match(input logic [ADDR_WIDTH-1:0] a,
                                           input logic [ADDR_WIDTH-1:0] b);
        return (a >> GRANULE_BITS) == (b >> GRANULE_BITS);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] granule_align(input logic [ADDR_WIDTH-1:0] a);
        return (a >> GRANULE_BITS) << GRANULE_BITS;
    endfunction

    // SC wins over LR when both qualifiers are set
    assign commit    = valid & ~stall;
    assign sc_commit = commit & isSc;
    assign lr_commit = commit & isLr & ~isSc;
    assign st_commit = commit & memWrite & ~isSc & granule_match(address, reservedAddress);

    assign sc_success = (state == RESERVED) & granule_match(address, reservedAddress)
                        & ~(snoopValid & granule_match(snoopAddress, reservedAddress));

    assign scWriteEnable    = valid & isSc & sc_success;
    assign scResult         = {31'b0, ~sc_success};
    assign reservationValid = (state == RESERVED);

`ifdef RESERVATION_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] counter;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (lr_commit) begin
            counter <= '0;
        end else if (state == RESERVED) begin
            counter <= counter + 1'b1;
        end
    end

    assign expired = (state == RESERVED) & (counter == CNT_LAST) & ~lr_commit;
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        addr_nxt  = reservedAddress;
        if (sc_commit) begin
            state_nxt = IDLE;
        end else if (lr_commit) begin
            state_nxt = RESERVED;
            addr_nxt  = granule_align(address);
        end else if (st_commit) begin
            state_nxt = IDLE;
        end
        if (expired) begin
            state_nxt = IDLE;
        end
        // snoop is checked against the post-update granule, so a same-cycle LR is cancelled
        if (snoopValid && granule_match(snoopAddress, addr_nxt)) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            reservedAddress <= '0;
        end else begin
            state           <= state_nxt;
            reservedAddress <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_lr_sc_reservation_unit.sv
// Directed bench for lr_sc_reservation_unit; expiry checks follow RESERVATION_TIMEOUT_EN.
module tb_lr_sc_reservation_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid, stall, isLr, isSc, memWrite, snoopValid;
    logic [31:0] address, snoopAddress;
    logic        scWriteEnable;
    logic [31:0] scResult;
    logic        reservationValid;
    logic [31:0] reservedAddress;

    int n_checks = 0;
    int n_fails  = 0;

    lr_sc_reservation_unit #(
        .ADDR_WIDTH(32), .GRANULE_BITS(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .stall(stall),
        .isLr(isLr), .isSc(isSc), .memWrite(memWrite), .address(address),
        .snoopValid(snoopValid), .snoopAddress(snoopAddress),
        .scWriteEnable(scWriteEnable), .scResult(scResult),
        .reservationValid(reservationValid), .reservedAddress(reservedAddress)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // inputs change 1 time unit after a rising edge; combinational outputs settle 1 unit later
    task automatic drive(input logic v, input logic st, input logic lr, input logic sc,
                         input logic mw, input logic [31:0] a,
                         input logic sv, input logic [31:0] sa);
        valid = v; stall = st; isLr = lr; isSc = sc; memWrite = mw; address = a;
        snoopValid = sv; snoopAddress = sa;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lr(input logic [31:0] a);
        drive(1, 0, 1, 0, 0, a, 0, 32'h0);
        tick();
    endtask

    task automatic do_sc(input string tag, input logic [31:0] a, input logic ok);
        drive(1, 0, 0, 1, 1, a, 0, 32'h0);
        check({tag, "_we"}, {31'b0, scWriteEnable}, {31'b0, ok});
        check({tag, "_res"}, scResult, ok ? 32'd0 : 32'd1);
        tick();
        check({tag, "_rv_after"}, {31'b0, reservationValid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 0, 0, 1, 1, 32'h0, 0, 32'h0);
        check("rst_rv", {31'b0, reservationValid}, 32'd0);
        check("rst_ra", reservedAddress, 32'h0);
        check("rst_we", {31'b0, scWriteEnable}, 32'd0);
        check("rst_res", scResult, 32'd1);
        tick();
        idle();
        reset = 1'b0;
        tick();

        // basic LR/SC pair
        do_lr(32'h100);
        check("lr1_rv", {31'b0, reservationValid}, 32'd1);
        check("lr1_ra", reservedAddress, 32'h100);
        do_sc("sc1", 32'h100, 1'b1);

        // different word fails, same word different byte succeeds
        do_lr(32'h100);
        do_sc("sc_104", 32'h104, 1'b0);
        do_lr(32'h103);
        check("lr_align", reservedAddress, 32'h100);
        do_sc("sc_102", 32'h102, 1'b1);

        // plain stores
        do_lr(32'h200);
        drive(1, 0, 0, 0, 1, 32'h200, 0, 32'h0);
        tick();
        check("st_match_rv", {31'b0, reservationValid}, 32'd0);
        do_sc("sc_after_st", 32'h200, 1'b0);
        do_lr(32'h200);
        drive(1, 0, 0, 0, 1, 32'h300, 0, 32'h0);
        tick();
        check("st_other_rv", {31'b0, reservationValid}, 32'd1);
        do_sc("sc_after_st2", 32'h200, 1'b1);

        // snoop
        do_lr(32'h300);
        drive(1, 0, 0, 1, 1, 32'h300, 1, 32'h300);
        check("snp_sc_we", {31'b0, scWriteEnable}, 32'd0);
        check("snp_sc_res", scResult, 32'd1);
        tick();
        drive(1, 0, 1, 0, 0, 32'h300, 1, 32'h302);
        tick();
        check("lr_snp_rv", {31'b0, reservationValid}, 32'd0);
        drive(1, 0, 1, 0, 0, 32'h300, 1, 32'h304);
        tick();
        check("lr_snp_other_rv", {31'b0, reservationValid}, 32'd1);
        drive(0, 0, 0, 0, 0, 32'h0, 1, 32'h301);
        tick();
        check("snp_idle_rv", {31'b0, reservationValid}, 32'd0);

        // stalled SC still flags the write but keeps the reservation
        do_lr(32'h400);
        drive(1, 1, 0, 1, 1, 32'h400, 0, 32'h0);
        check("sc_stall_we", {31'b0, scWriteEnable}, 32'd1);
        tick();
        check("sc_stall_rv", {31'b0, reservationValid}, 32'd1);
        do_sc("sc_post_stall", 32'h400, 1'b1);

        // LR replacement and LR+SC together
        do_lr(32'h500);
        do_lr(32'h600);
        check("lr_repl_ra", reservedAddress, 32'h600);
        do_sc("sc_old", 32'h500, 1'b0);
        do_lr(32'h700);
        drive(1, 0, 1, 1, 1, 32'h700, 0, 32'h0);
        check("lrsc_we", {31'b0, scWriteEnable}, 32'd1);
        tick();
        check("lrsc_rv", {31'b0, reservationValid}, 32'd0);
        drive(1, 0, 1, 1, 1, 32'h700, 0, 32'h0);
        check("lrsc_idle_res", scResult, 32'd1);
        tick();
        check("lrsc_idle_rv", {31'b0, reservationValid}, 32'd0);

        // asynchronous reset while reserved
        do_lr(32'h800);
        idle();
        reset = 1'b1;
        #1;
        check("arst_rv", {31'b0, reservationValid}, 32'd0);
        check("arst_ra", reservedAddress, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        do_sc("sc_after_rst", 32'h800, 1'b0);

        // stalled LR
        drive(1, 1, 1, 0, 0, 32'h900, 0, 32'h0);
        tick();
        check("lr_stall_rv", {31'b0, reservationValid}, 32'd0);

`ifdef RESERVATION_TIMEOUT_EN
        do_lr(32'hA00);
        idle();
        repeat (63) tick();
        do_sc("sc_k64", 32'hA00, 1'b1);
        do_lr(32'hA00);
        idle();
        repeat (64) tick();
        check("to_rv", {31'b0, reservationValid}, 32'd0);
        do_sc("sc_k65", 32'hA00, 1'b0);
`else
        do_lr(32'hA00);
        idle();
        repeat (999) tick();
        check("long_rv", {31'b0, reservationValid}, 32'd1);
        do_sc("sc_k1000", 32'hA00, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
